// File: rtl/crossbar_ctrl.sv
// Packet arbiter/sequencer for the 2-port crossbar: round-robin grant per packet.
// Optional XBAR_STATS_EN adds packet/broadcast/abort counters.
module crossbar_ctrl #(
   parameter int MAX_PKT_BEATS = 256,
   parameter int BEAT_CNT_W    = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_p0,
   input  logic       req_p1,
   input  logic       bcast_p1,
   input  logic       valid_p0,
   input  logic       last_p0,
   input  logic       valid_p1,
   input  logic       last_p1,
   output logic [1:0] control_crossbar,
   output logic       gnt_p0,
   output logic       gnt_p1,
   output logic       busy,
   output logic       err_overlen
`ifdef XBAR_STATS_EN
   ,
   output logic [15:0] pkt_cnt_p0,
   output logic [15:0] pkt_cnt_p1,
   output logic [15:0] bcast_cnt,
   output logic [15:0] abort_cnt
`endif
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_P0   = 3'd1;
   localparam logic [2:0] S_P1   = 3'd2;
   localparam logic [2:0] S_BC   = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;

   localparam logic [BEAT_CNT_W-1:0] LIMIT =
      BEAT_CNT_W'(MAX_PKT_BEATS - 1);

   logic [2:0]            r_state, w_next;
   logic [BEAT_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic                  r_ptr, w_ptr_nxt;
   logic                  w_beat, w_last, w_abort, w_done;
   logic [1:0]            r_code, w_code;
   logic                  r_gnt0, r_gnt1, r_busy, r_err;

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_ptr_nxt = r_ptr;
      w_abort   = 1'b0;
      w_beat    = 1'b0;
      w_last    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // r_ptr = 0 favours P0 when both ports request
            if (req_p0 && (!req_p1 || !r_ptr))
               w_next = S_P0;
            else if (req_p1)
               w_next = bcast_p1 ? S_BC : S_P1;
         end
         S_P0, S_P1, S_BC: begin
            w_beat = (r_state == S_P0) ? valid_p0 : valid_p1;
            w_last = (r_state == S_P0) ? last_p0  : last_p1;
            if (w_beat) begin
               if (w_last || r_cnt == LIMIT) begin
                  w_next    = S_GAP;
                  w_cnt_nxt = '0;
                  w_abort   = !w_last;
                  w_ptr_nxt = (r_state == S_P0);
               end else begin
                  w_cnt_nxt = r_cnt + BEAT_CNT_W'(1);
               end
            end
         end
         S_GAP:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_done = (w_next == S_GAP) && (r_state != S_GAP);

   always_comb begin
      w_code = 2'b00;
      case (w_next)
         S_P0:    w_code = 2'b01;
         S_P1:    w_code = 2'b10;
         S_BC:    w_code = 2'b11;
         default: w_code = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= 1'b0;
         r_code  <= 2'b00;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_code  <= w_code;
         r_gnt0  <= (w_next == S_P0);
         r_gnt1  <= (w_next == S_P1) || (w_next == S_BC);
         r_busy  <= (w_next != S_IDLE);
         r_err   <= w_abort;
      end
   end

   assign control_crossbar = r_code;
   assign gnt_p0           = r_gnt0;
   assign gnt_p1           = r_gnt1;
   assign busy             = r_busy;
   assign err_overlen      = r_err;

`ifdef XBAR_STATS_EN
   logic [15:0] r_pkt0, r_pkt1, r_bc, r_abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pkt0  <= '0;
         r_pkt1  <= '0;
         r_bc    <= '0;
         r_abort <= '0;
      end else begin
         if (w_done && r_state == S_P0)
            r_pkt0 <= r_pkt0 + 16'd1;
         if (w_done && r_state != S_P0)
            r_pkt1 <= r_pkt1 + 16'd1;
         if (w_done && r_state == S_BC)
            r_bc <= r_bc + 16'd1;
         if (w_abort)
            r_abort <= r_abort + 16'd1;
      end
   end

   assign pkt_cnt_p0 = r_pkt0;
   assign pkt_cnt_p1 = r_pkt1;
   assign bcast_cnt  = r_bc;
   assign abort_cnt  = r_abort;
`else
   logic w_unused;
   assign w_unused = w_done;
`endif

endmodule

// File: tb/tb_crossbar_ctrl.sv
// Scoreboard bench for crossbar_ctrl (MAX_PKT_BEATS=4): expected output
// vectors are queued as stimulus is driven and checked after each edge.
module tb_crossbar_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_p0 = 1'b0, req_p1 = 1'b0, bcast_p1 = 1'b0;
   logic       valid_p0 = 1'b0, last_p0 = 1'b0;
   logic       valid_p1 = 1'b0, last_p1 = 1'b0;
   logic [1:0] control_crossbar;
   logic       gnt_p0, gnt_p1, busy, err_overlen;
`ifdef XBAR_STATS_EN
   logic [15:0] pkt_cnt_p0, pkt_cnt_p1, bcast_cnt, abort_cnt;
`endif

   int total = 0;
   int bad   = 0;
   logic [5:0] exp_q [$];

   // {code, gnt_p0, gnt_p1, busy, err}
   localparam logic [5:0] E_ID = 6'b00_0_0_0_0;
   localparam logic [5:0] E_P0 = 6'b01_1_0_1_0;
   localparam logic [5:0] E_P1 = 6'b10_0_1_1_0;
   localparam logic [5:0] E_BC = 6'b11_0_1_1_0;
   localparam logic [5:0] E_GP = 6'b00_0_0_1_0;
   localparam logic [5:0] E_AB = 6'b00_0_0_1_1;

   crossbar_ctrl #(.MAX_PKT_BEATS(4), .BEAT_CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .req_p0(req_p0), .req_p1(req_p1), .bcast_p1(bcast_p1),
      .valid_p0(valid_p0), .last_p0(last_p0),
      .valid_p1(valid_p1), .last_p1(last_p1),
      .control_crossbar(control_crossbar),
      .gnt_p0(gnt_p0), .gnt_p1(gnt_p1),
      .busy(busy), .err_overlen(err_overlen)
`ifdef XBAR_STATS_EN
      ,
      .pkt_cnt_p0(pkt_cnt_p0), .pkt_cnt_p1(pkt_cnt_p1),
      .bcast_cnt(bcast_cnt), .abort_cnt(abort_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] outs();
      return {control_crossbar, gnt_p0, gnt_p1, busy, err_overlen};
   endfunction

   // s = {req_p0, req_p1, bcast_p1, valid_p0, last_p0, valid_p1, last_p1}
   task automatic drv(input logic [6:0] s, input logic [5:0] e);
      {req_p0, req_p1, bcast_p1, valid_p0, last_p0, valid_p1, last_p1} = s;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [5:0] e;
      drv(7'b0, E_ID);
      e = exp_q.pop_front();
      total++;
      if (outs() !== e) begin
         bad++;
         $display("FAIL reset got=%b want=%b", outs(), e);
      end
      rst = 1'b0;
   endtask

   task automatic test_alternate;
      logic [12:0] t [$];
      logic [5:0]  e;
      t = '{{7'b1100000, E_P0}, {7'b1101010, E_P0}, {7'b1101111, E_GP},
            {7'b1100000, E_ID}, {7'b1100000, E_P1}, {7'b1101010, E_P1},
            {7'b1101111, E_GP}, {7'b1100000, E_ID}, {7'b1100000, E_P0},
            {7'b1101100, E_GP}, {7'b0000000, E_ID}};
      foreach (t[i]) begin
         drv(t[i][12:6], t[i][5:0]);
         e = exp_q.pop_front();
         total++;
         if (outs() !== e) begin
            bad++;
            $display("FAIL alternate[%0d] got=%b want=%b", i, outs(), e);
         end
      end
   endtask

   task automatic test_basic;
      logic [12:0] t [$];
      logic [5:0]  e;
      t = '{{7'b1000000, E_P0}, {7'b0001000, E_P0}, {7'b0001000, E_P0},
            {7'b0001100, E_GP}, {7'b0000000, E_ID}};
      foreach (t[i]) begin
         drv(t[i][12:6], t[i][5:0]);
         e = exp_q.pop_front();
         total++;
         if (outs() !== e) begin
            bad++;
            $display("FAIL basic[%0d] got=%b want=%b", i, outs(), e);
         end
      end
   endtask

   task automatic test_bcast;
      logic [12:0] t [$];
      logic [5:0]  e;
      t = '{{7'b0110000, E_BC}, {7'b0110010, E_BC}, {7'b0100010, E_BC},
            {7'b0000010, E_BC}, {7'b0000011, E_GP}, {7'b0000000, E_ID}};
      foreach (t[i]) begin
         drv(t[i][12:6], t[i][5:0]);
         e = exp_q.pop_front();
         total++;
         if (outs() !== e) begin
            bad++;
            $display("FAIL bcast[%0d] got=%b want=%b", i, outs(), e);
         end
      end
   endtask

   task automatic test_other_port;
      logic [12:0] t [$];
      logic [5:0]  e;
      t = '{{7'b0100000, E_P1}, {7'b0001100, E_P1}, {7'b0001110, E_P1},
            {7'b1001100, E_P1}, {7'b0000011, E_GP}, {7'b0000000, E_ID}};
      foreach (t[i]) begin
         drv(t[i][12:6], t[i][5:0]);
         e = exp_q.pop_front();
         total++;
         if (outs() !== e) begin
            bad++;
            $display("FAIL other_port[%0d] got=%b want=%b", i, outs(), e);
         end
      end
   endtask

   task automatic test_abort;
      logic [12:0] t [$];
      logic [5:0]  e;
      t = '{{7'b1000000, E_P0}, {7'b0001000, E_P0}, {7'b0001000, E_P0},
            {7'b0001000, E_P0}, {7'b0001000, E_AB}, {7'b0001000, E_ID},
            {7'b0000000, E_ID}};
      foreach (t[i]) begin
         drv(t[i][12:6], t[i][5:0]);
         e = exp_q.pop_front();
         total++;
         if (outs() !== e) begin
            bad++;
            $display("FAIL abort[%0d] got=%b want=%b", i, outs(), e);
         end
      end
   endtask

   task automatic test_limit_last;
      logic [12:0] t [$];
      logic [5:0]  e;
      t = '{{7'b1000000, E_P0}, {7'b0001000, E_P0}, {7'b0001000, E_P0},
            {7'b0001000, E_P0}, {7'b0001100, E_GP}, {7'b0000000, E_ID}};
      foreach (t[i]) begin
         drv(t[i][12:6], t[i][5:0]);
         e = exp_q.pop_front();
         total++;
         if (outs() !== e) begin
            bad++;
            $display("FAIL limit_last[%0d] got=%b want=%b", i, outs(), e);
         end
      end
   endtask

`ifdef XBAR_STATS_EN
   task automatic test_stats(input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] bc, input logic [15:0] ab);
      total++;
      if (pkt_cnt_p0 !== p0) begin
         bad++;
         $display("FAIL stats_p0 got=%0d want=%0d", pkt_cnt_p0, p0);
      end
      total++;
      if (pkt_cnt_p1 !== p1) begin
         bad++;
         $display("FAIL stats_p1 got=%0d want=%0d", pkt_cnt_p1, p1);
      end
      total++;
      if (bcast_cnt !== bc) begin
         bad++;
         $display("FAIL stats_bc got=%0d want=%0d", bcast_cnt, bc);
      end
      total++;
      if (abort_cnt !== ab) begin
         bad++;
         $display("FAIL stats_abort got=%0d want=%0d", abort_cnt, ab);
      end
   endtask
`endif

   task automatic test_reset_mid;
      logic [12:0] t [$];
      logic [5:0]  e;
      drv(7'b0110000, E_BC);
      drv(7'b0000010, E_BC);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         total++;
         if (outs() !== e) begin
            bad++;
            $display("FAIL reset_mid_pre[%0d] got=%b want=%b", i, outs(), e);
         end
      end
      #2;
      rst = 1'b1;
      exp_q.push_back(E_ID);
      #1;
      e = exp_q.pop_front();
      total++;
      if (outs() !== e) begin
         bad++;
         $display("FAIL reset_mid_async got=%b want=%b", outs(), e);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      t = '{{7'b1100000, E_P0}, {7'b0001100, E_GP}, {7'b0000000, E_ID}};
      foreach (t[i]) begin
         drv(t[i][12:6], t[i][5:0]);
         e = exp_q.pop_front();
         total++;
         if (outs() !== e) begin
            bad++;
            $display("FAIL reset_mid_post[%0d] got=%b want=%b", i, outs(), e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_basic();
      test_bcast();
      test_other_port();
      test_abort();
      test_limit_last();
`ifdef XBAR_STATS_EN
      test_stats(16'd5, 16'd3, 16'd1, 16'd1);
`endif
      test_reset_mid();
`ifdef XBAR_STATS_EN
      test_stats(16'd1, 16'd0, 16'd0, 16'd0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crossbar_ctrl.md
Name: crossbar_ctrl

Overview:
Packet-level arbiter and sequencer for the 2-port 4-lane crossbar. It accepts transfer requests from port 0 (forward to port 1) and port 1 (to port 0, or broadcast to both). It drives the crossbar's 2-bit control code, holding each grant for a whole packet (up to last beat), with round-robin fairness and a forced idle gap between packets.

Parameters:
MAX_PKT_BEATS, 256, beat limit per packet; reaching it without last aborts the grant
BEAT_CNT_W, 9, beat counter width; must satisfy 2^BEAT_CNT_W > MAX_PKT_BEATS

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
req_p0  input  1  port 0 has a packet destined for port 1
req_p1  input  1  port 1 has a packet destined for port 0
bcast_p1  input  1  port 1 packet is broadcast; qualified by req_p1
valid_p0  input  1  port 0 beat valid this cycle
last_p0  input  1  port 0 final beat of packet; qualified by valid_p0
valid_p1  input  1  port 1 beat valid this cycle
last_p1  input  1  port 1 final beat of packet; qualified by valid_p1
control_crossbar  output  2  crossbar code: 00 none, 01 p0->p1, 10 p1->p0, 11 p1->both; registered
gnt_p0  output  1  port 0 owns crossbar; registered
gnt_p1  output  1  port 1 owns crossbar (unicast or broadcast); registered
busy  output  1  state != IDLE; registered
err_overlen  output  1  one-cycle pulse on beat-limit abort

Behaviour:
- Reset (async assert, sync release): state IDLE, control_crossbar=00, gnt_p0=gnt_p1=0, busy=0, err_overlen=0, beat_cnt=0, priority pointer = P0.
- States: IDLE, GNT_P0 (code 01, gnt_p0=1), GNT_P1 (code 10, gnt_p1=1), GNT_BC (code 11, gnt_p1=1), GAP (code 00, no grants, busy=1).
- All outputs are registered and decoded from the next state. Code and grant change on the same edge as the state.
- IDLE:
  - Only req_p0 -> GNT_P0.
  - Only req_p1 -> GNT_BC if bcast_p1, else GNT_P1.
  - Both requests -> the pointer's port wins.
  - Latency: request sampled at edge N gives code/grant visible after edge N (1 cycle).
- bcast_p1 is sampled only on the IDLE->grant edge. Later changes are ignored until the next grant.
- Grant states:
  - A beat counts when the owner's valid is 1. The other port's valid/last are ignored.
  - req_* is ignored while granted. Deasserting req mid-packet does not release the grant; only last does.
  - Owner valid && last -> GAP. beat_cnt clears.
  - Beat counted while beat_cnt == MAX_PKT_BEATS-1 with no last -> GAP, err_overlen=1 for 1 cycle, beat_cnt clears.
  - A last on the limit beat is a normal completion with no error.
- GAP: exactly 1 cycle with code 00, then IDLE. Minimum spacing: last at cycle N, GAP N+1, IDLE N+2, new grant visible N+3.
- Pointer:
  - Updated on leaving a grant state: after GNT_P0 it points to P1; after GNT_P1/GNT_BC it points to P0.
  - Not updated on abort-free idle cycles.
  - Applies to aborts as well as normal completion.
- Single-beat packet (valid && last on the first granted cycle): grant lasts 1 cycle, then GAP.
- Reset mid-packet: immediate return to reset values. Crossbar code 00 asynchronously.

Optional Feature:
XBAR_STATS_EN:
- Defined: adds outputs pkt_cnt_p0 [15:0], pkt_cnt_p1 [15:0], bcast_cnt [15:0], abort_cnt [15:0].
  - Each increments on the completing (or aborting) edge of the corresponding grant. pkt_cnt_p1 counts both unicast and broadcast.
  - abort_cnt counts err_overlen pulses; aborted packets also count in their port counter.
  - All counters wrap 0xFFFF->0x0000 and reset to 0.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then req_p0=1 at edge 1 -> after edge 1 control_crossbar=01, gnt_p0=1. Three valid_p0 beats with last on the 3rd -> GAP (00) next cycle, then IDLE.
- req_p0=req_p1=1 held continuously, 2-beat packets -> grants alternate P0, P1, P0, P1, with code sequence 01,01,00,00,10,10,00,00,01...
- req_p1=1, bcast_p1=1 at grant, bcast_p1 dropped mid-packet -> code stays 11 until last_p1, gnt_p1=1, gnt_p0=0.
- MAX_PKT_BEATS=4, valid_p0 held, last never asserted -> after the 4th beat, err_overlen pulses once, code 00, then IDLE. With XBAR_STATS_EN: abort_cnt=1, pkt_cnt_p0=1.
- During GNT_P1, valid_p0=1 with last_p0=1 and req_p1 deasserted -> no state change, grant held until last_p1.
- rst asserted mid-GNT_BC -> control_crossbar=00, gnt_p1=0, busy=0 immediately. After release with req_p0=req_p1=1 -> P0 is granted first.
